// File: rtl/bp_be_commit_trace_buffer.sv
// Commit-event capture for the BE tracers: follows dispatched instructions to the CMT slot,
// builds commit/trap/ret records and buffers them in a FIFO drained over valid/ready.
module bp_be_commit_trace_buffer #(
    parameter int unsigned vaddr_width_p    = 39,
    parameter int unsigned instr_width_p    = 32,
    parameter int unsigned dword_width_p    = 64,
    parameter int unsigned fifo_els_p       = 8,
    parameter int unsigned seq_width_p      = 32,
    parameter int unsigned drop_cnt_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        freeze_i,
    input  logic                        disp_v_i,
    input  logic [vaddr_width_p-1:0]    disp_pc_i,
    input  logic [instr_width_p-1:0]    disp_instr_i,
    input  logic                        disp_irf_w_v_i,
    input  logic [2:0]                  poison_i,
    input  logic [dword_width_p-1:0]    cmt_result_i,
    input  logic                        trap_v_i,
    input  logic                        ret_v_i,
    output logic                        trace_v_o,
    input  logic                        trace_ready_i,
    output logic [1:0]                  trace_type_o,
    output logic [vaddr_width_p-1:0]    trace_pc_o,
    output logic [instr_width_p-1:0]    trace_instr_o,
    output logic                        trace_rd_w_o,
    output logic [4:0]                  trace_rd_addr_o,
    output logic [dword_width_p-1:0]    trace_data_o,
    output logic [seq_width_p-1:0]      trace_seq_o,
    output logic [drop_cnt_width_p-1:0] drop_cnt_o,
    output logic                        overflow_o
);

    localparam int unsigned ptr_w_lp = $clog2(fifo_els_p);

    // Pipeline shadow stages
    logic                     ex1_v_q, ex2_v_q, cmt_v_q;
    logic [vaddr_width_p-1:0] ex1_pc_q, ex2_pc_q, cmt_pc_q;
    logic [instr_width_p-1:0] ex1_instr_q, ex2_instr_q, cmt_instr_q;
    logic                     ex1_irf_w_q, ex2_irf_w_q, cmt_irf_w_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ex1_v_q     <= 1'b0;
            ex2_v_q     <= 1'b0;
            cmt_v_q     <= 1'b0;
            ex1_pc_q    <= '0;
            ex2_pc_q    <= '0;
            cmt_pc_q    <= '0;
            ex1_instr_q <= '0;
            ex2_instr_q <= '0;
            cmt_instr_q <= '0;
            ex1_irf_w_q <= 1'b0;
            ex2_irf_w_q <= 1'b0;
            cmt_irf_w_q <= 1'b0;
        end else begin
            ex1_v_q     <= disp_v_i & ~freeze_i;
            ex2_v_q     <= ex1_v_q & ~poison_i[0] & ~freeze_i;
            cmt_v_q     <= ex2_v_q & ~poison_i[1] & ~freeze_i;
            ex1_pc_q    <= disp_pc_i;
            ex2_pc_q    <= ex1_pc_q;
            cmt_pc_q    <= ex2_pc_q;
            ex1_instr_q <= disp_instr_i;
            ex2_instr_q <= ex1_instr_q;
            cmt_instr_q <= ex2_instr_q;
            ex1_irf_w_q <= disp_irf_w_v_i;
            ex2_irf_w_q <= ex1_irf_w_q;
            cmt_irf_w_q <= ex2_irf_w_q;
        end
    end

    // A trap is recorded even on a poisoned slot; commit/ret are not
    logic       ev_v;
    logic [1:0] ev_type;

    always_comb begin
        ev_v    = 1'b0;
        ev_type = 2'd0;
        if (cmt_v_q && !freeze_i) begin
            if (trap_v_i) begin
                ev_v    = 1'b1;
                ev_type = 2'd1;
            end else if (!poison_i[2]) begin
                ev_v    = 1'b1;
                ev_type = ret_v_i ? 2'd2 : 2'd0;
            end
        end
    end

    // Record FIFO with an extra wrap bit on each pointer
    logic [ptr_w_lp:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0] wr_idx, rd_idx;
    logic                empty, full, enq, deq, drop;

    logic [1:0]               mem_type_q  [fifo_els_p];
    logic [vaddr_width_p-1:0] mem_pc_q    [fifo_els_p];
    logic [instr_width_p-1:0] mem_instr_q [fifo_els_p];
    logic                     mem_rd_w_q  [fifo_els_p];
    logic [dword_width_p-1:0] mem_data_q  [fifo_els_p];
    logic [seq_width_p-1:0]   mem_seq_q   [fifo_els_p];

    logic [seq_width_p-1:0]      seq_q, seq_d;
    logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;
    logic                        overflow_q, overflow_d;

    assign wr_idx = wr_ptr_q[ptr_w_lp-1:0];
    assign rd_idx = rd_ptr_q[ptr_w_lp-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp]) && (wr_idx == rd_idx);
    assign deq    = ~empty & trace_ready_i;
    assign enq    = ev_v & (~full | deq);
    assign drop   = ev_v & full & ~deq;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (enq) wr_ptr_d = wr_ptr_q + {{ptr_w_lp{1'b0}}, 1'b1};
        if (deq) rd_ptr_d = rd_ptr_q + {{ptr_w_lp{1'b0}}, 1'b1};
        if (ev_v) seq_d = seq_q + {{(seq_width_p-1){1'b0}}, 1'b1};
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + {{(drop_cnt_width_p-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_type_q[wr_idx]  <= ev_type;
            mem_pc_q[wr_idx]    <= cmt_pc_q;
            mem_instr_q[wr_idx] <= cmt_instr_q;
            mem_rd_w_q[wr_idx]  <= (ev_type == 2'd0) & cmt_irf_w_q;
            mem_data_q[wr_idx]  <= cmt_result_i;
            mem_seq_q[wr_idx]   <= seq_q;
        end
    end

    assign trace_v_o       = ~empty;
    assign trace_type_o    = trace_v_o ? mem_type_q[rd_idx] : '0;
    assign trace_pc_o      = trace_v_o ? mem_pc_q[rd_idx] : '0;
    assign trace_instr_o   = trace_v_o ? mem_instr_q[rd_idx] : '0;
    assign trace_rd_w_o    = trace_v_o & mem_rd_w_q[rd_idx];
    assign trace_rd_addr_o = trace_v_o ? mem_instr_q[rd_idx][11:7] : '0;
    assign trace_data_o    = trace_v_o ? mem_data_q[rd_idx] : '0;
    assign trace_seq_o     = trace_v_o ? mem_seq_q[rd_idx] : '0;
    assign drop_cnt_o      = drop_cnt_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_bp_be_commit_trace_buffer.sv
// Randomised scoreboard bench for bp_be_commit_trace_buffer with directed corner cases.
module tb_bp_be_commit_trace_buffer;

    localparam int unsigned VW  = 39;
    localparam int unsigned IW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned FE  = 8;
    localparam int unsigned SW  = 32;
    localparam int unsigned DCW = 16;

    logic           clk_i = 1'b0;
    logic           reset_i = 1'b1;
    logic           freeze_i = 1'b0;
    logic           disp_v_i = 1'b0;
    logic [VW-1:0]  disp_pc_i = '0;
    logic [IW-1:0]  disp_instr_i = '0;
    logic           disp_irf_w_v_i = 1'b0;
    logic [2:0]     poison_i = '0;
    logic [DW-1:0]  cmt_result_i = '0;
    logic           trap_v_i = 1'b0;
    logic           ret_v_i = 1'b0;
    logic           trace_v_o;
    logic           trace_ready_i = 1'b1;
    logic [1:0]     trace_type_o;
    logic [VW-1:0]  trace_pc_o;
    logic [IW-1:0]  trace_instr_o;
    logic           trace_rd_w_o;
    logic [4:0]     trace_rd_addr_o;
    logic [DW-1:0]  trace_data_o;
    logic [SW-1:0]  trace_seq_o;
    logic [DCW-1:0] drop_cnt_o;
    logic           overflow_o;

    bp_be_commit_trace_buffer #(
        .vaddr_width_p(VW), .instr_width_p(IW), .dword_width_p(DW),
        .fifo_els_p(FE), .seq_width_p(SW), .drop_cnt_width_p(DCW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .freeze_i(freeze_i), .disp_v_i(disp_v_i),
        .disp_pc_i(disp_pc_i), .disp_instr_i(disp_instr_i), .disp_irf_w_v_i(disp_irf_w_v_i),
        .poison_i(poison_i), .cmt_result_i(cmt_result_i), .trap_v_i(trap_v_i),
        .ret_v_i(ret_v_i), .trace_v_o(trace_v_o), .trace_ready_i(trace_ready_i),
        .trace_type_o(trace_type_o), .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
        .trace_rd_w_o(trace_rd_w_o), .trace_rd_addr_o(trace_rd_addr_o),
        .trace_data_o(trace_data_o), .trace_seq_o(trace_seq_o), .drop_cnt_o(drop_cnt_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]    typ;
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
        logic          rd_w;
        logic [4:0]    rd_addr;
        logic [DW-1:0] data;
        logic [SW-1:0] seq;
    } rec_t;

    typedef struct {
        logic          disp_v;
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
        logic          irf_w;
        logic          frz;
        logic [2:0]    p;
    } hist_t;

    // Model state: last four cycles of inputs, queued records, counters
    hist_t       h[4];
    rec_t        sb[$];
    int unsigned cnt, drop, vis_cnt, vis_drop;
    logic        ovf, vis_ovf;
    logic [SW-1:0] mseq;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction dispatched three cycles ago reaches CMT
    // unless freeze or the relevant poison bit hit it on the way.
    always @(negedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++) h[i] = '{default: '0};
            sb.delete();
            cnt = 0; drop = 0; ovf = 1'b0; mseq = '0;
            vis_cnt = 0; vis_drop = 0; vis_ovf = 1'b0;
        end else begin
            bit   at_cmt, built, deq, enq;
            rec_t r;
            vis_cnt = cnt; vis_drop = drop; vis_ovf = ovf;
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0];
            h[0] = '{disp_v: disp_v_i, pc: disp_pc_i, instr: disp_instr_i,
                     irf_w: disp_irf_w_v_i, frz: freeze_i, p: poison_i};
            at_cmt = h[3].disp_v && !h[3].frz && !h[2].p[0] && !h[2].frz
                     && !h[1].p[1] && !h[1].frz;
            built = at_cmt && !freeze_i && (trap_v_i || !poison_i[2]);
            deq = (cnt != 0) && trace_ready_i;
            enq = 1'b0;
            if (built) begin
                r.typ     = trap_v_i ? 2'd1 : (ret_v_i ? 2'd2 : 2'd0);
                r.pc      = h[3].pc;
                r.instr   = h[3].instr;
                r.rd_w    = (r.typ == 2'd0) && h[3].irf_w;
                r.rd_addr = h[3].instr[11:7];
                r.data    = cmt_result_i;
                r.seq     = mseq;
                mseq      = mseq + 1;
                if (cnt < FE || deq) begin
                    sb.push_back(r);
                    enq = 1'b1;
                end else begin
                    ovf = 1'b1;
                    if (drop < 65535) drop++;
                end
            end
            cnt = cnt + int'(enq) - int'(deq);
        end
    end

    // Monitor: compares the presented head against the scoreboard front
    always @(negedge clk_i) begin
        #2;
        if (!reset_i) begin
            chk("trace_v", 64'(trace_v_o), 64'(vis_cnt != 0));
            chk("drop_cnt", 64'(drop_cnt_o), 64'(vis_drop));
            chk("overflow", 64'(overflow_o), 64'(vis_ovf));
            if (!trace_v_o) begin
                chk("idle_pc", 64'(trace_pc_o), 64'd0);
                chk("idle_data_seq", 64'(trace_data_o) | 64'(trace_seq_o), 64'd0);
            end else if (sb.size() == 0) begin
                chk("unexpected_record", 64'(trace_seq_o), 64'hffff_ffff_ffff_ffff);
            end else begin
                chk("rec_type", 64'(trace_type_o), 64'(sb[0].typ));
                chk("rec_pc", 64'(trace_pc_o), 64'(sb[0].pc));
                chk("rec_instr", 64'(trace_instr_o), 64'(sb[0].instr));
                chk("rec_rd_w", 64'(trace_rd_w_o), 64'(sb[0].rd_w));
                chk("rec_rd_addr", 64'(trace_rd_addr_o), 64'(sb[0].rd_addr));
                chk("rec_data", trace_data_o, sb[0].data);
                chk("rec_seq", 64'(trace_seq_o), 64'(sb[0].seq));
                if (trace_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        cmt_result_i = {$urandom, $urandom};
    endtask

    task automatic idle();
        disp_v_i = 1'b0; poison_i = '0; trap_v_i = 1'b0; ret_v_i = 1'b0; freeze_i = 1'b0;
    endtask

    task automatic set_disp(input logic [VW-1:0] pc);
        disp_v_i = 1'b1;
        disp_pc_i = pc;
        disp_instr_i = $urandom;
        disp_irf_w_v_i = 1'($urandom);
    endtask

    task automatic do_reset();
        idle();
        trace_ready_i = 1'b1;
        reset_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;
    endtask

    initial begin
        do_reset();
        // Single commit reaches the output four cycles after dispatch
        set_disp(39'h80000000);
        tick(); idle(); tick(); tick();
        chk("t1_not_early", 64'(trace_v_o), 64'd0);
        tick();
        chk("t1_valid", 64'(trace_v_o), 64'd1);
        chk("t1_seq", 64'(trace_seq_o), 64'd0);
        chk("t1_type", 64'(trace_type_o), 64'd0);
        chk("t1_pc", 64'(trace_pc_o), 64'h80000000);
        repeat (3) tick();

        // EX2 poison kills the record; next clean instruction takes seq 0
        do_reset();
        set_disp(39'h80000100);
        tick(); idle(); tick();
        poison_i = 3'b010;
        set_disp(39'h80000104);
        tick(); idle(); tick();
        chk("t2_poisoned_none", 64'(trace_v_o), 64'd0);
        tick(); tick();
        chk("t2_valid", 64'(trace_v_o), 64'd1);
        chk("t2_seq", 64'(trace_seq_o), 64'd0);
        chk("t2_pc", 64'(trace_pc_o), 64'h80000104);
        repeat (3) tick();

        // Trap and ret together: one trap record only
        do_reset();
        set_disp(39'h80000200);
        tick(); idle(); tick(); tick();
        trap_v_i = 1'b1; ret_v_i = 1'b1;
        tick(); idle();
        chk("t3_type", 64'(trace_type_o), 64'd1);
        chk("t3_rd_w", 64'(trace_rd_w_o), 64'd0);
        repeat (4) tick();
        chk("t3_single", 64'(trace_v_o), 64'd0);

        // Overflow: ten commits into eight entries with the consumer stalled
        do_reset();
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_disp(39'h80001000 + 39'(4 * i));
            tick();
        end
        idle();
        repeat (6) tick();
        chk("t4_drop_cnt", 64'(drop_cnt_o), 64'd2);
        chk("t4_overflow", 64'(overflow_o), 64'd1);
        chk("t4_head_seq", 64'(trace_seq_o), 64'd0);
        trace_ready_i = 1'b1;
        repeat (10) tick();
        chk("t4_drained", 64'(trace_v_o), 64'd0);
        chk("t4_sticky", 64'(overflow_o), 64'd1);

        // Reset with records queued discards them at once
        trace_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(39'h80002000 + 39'(4 * i));
            tick();
        end
        idle();
        repeat (5) tick();
        chk("t6_queued", 64'(trace_v_o), 64'd1);
        reset_i = 1'b1;
        #1;
        chk("t6_async_v", 64'(trace_v_o), 64'd0);
        chk("t6_drop_clr", 64'(drop_cnt_o), 64'd0);
        chk("t6_ovf_clr", 64'(overflow_o), 64'd0);
        tick(); tick();
        reset_i = 1'b0;
        trace_ready_i = 1'b1;
        freeze_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_disp(39'h80003000 + 39'(4 * i));
            tick();
        end
        idle();
        repeat (6) tick();
        chk("t6_freeze_none", 64'(trace_v_o), 64'd0);

        // Full FIFO with a same-cycle dequeue and enqueue: nothing dropped
        do_reset();
        for (int k = 0; k < 21; k++) begin
            if (k < 11) set_disp(39'h80004000 + 39'(4 * k));
            else disp_v_i = 1'b0;
            trace_ready_i = (k >= 11);
            tick();
        end
        idle();
        trace_ready_i = 1'b1;
        repeat (10) tick();
        chk("t5_no_drop", 64'(drop_cnt_o), 64'd0);
        chk("t5_no_ovf", 64'(overflow_o), 64'd0);

        // Randomised traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) < 7) set_disp({8'h80, 31'($urandom)});
                else disp_v_i = 1'b0;
                poison_i = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                            ($urandom_range(0, 9) == 0)};
                trap_v_i = ($urandom_range(0, 19) == 0);
                ret_v_i = ($urandom_range(0, 19) == 0);
                freeze_i = ($urandom_range(0, 29) == 0);
                trace_ready_i = ($urandom_range(0, 9) < 6);
                tick();
            end
        end
        idle();
        trace_ready_i = 1'b1;
        repeat (20) tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_v", 64'(trace_v_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
